multicycle_mainfsm: RTL and testbench

// - Main control FSM + ALU decoder of the multicycle ARM core. Sits between the instruction register and

---
 rtl/multicycle_pkg.sv | 44 ++++
 rtl/multicycle_aludec.sv | 40 ++++
 rtl/multicycle_mainfsm.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_mainfsm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared encodings for the multicycle ARM control path
// (states, ALU control codes, opcode classes, datapath select values).
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        BLLINK   = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctl_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_aludec.sv
// multicycle_aludec: data-processing decode from cmd/S to ALU control, flag-write
// enables and the CMP register-write suppression; neutral (ADD, no flags) when ALUOp=0.
module multicycle_aludec
    import multicycle_pkg::*;
(
    input  logic       alu_op_i,
    input  logic [4:0] funct_i,
    output logic [1:0] alu_control_o,
    output logic [1:0] flag_w_o,
    output logic       no_write_o
);
    logic [3:0] cmd;
    logic       known;
    logic       arith;

    assign cmd = funct_i[4:1];

    always_comb begin
        alu_control_o = ALU_ADD;
        no_write_o    = 1'b0;
        known         = 1'b1;
        arith         = 1'b0;
        case (cmd)
            CMD_ADD: arith = 1'b1;
            CMD_SUB: begin alu_control_o = ALU_SUB; arith = 1'b1; end
            CMD_AND: alu_control_o = ALU_AND;
            CMD_ORR: alu_control_o = ALU_ORR;
            CMD_CMP: begin alu_control_o = ALU_SUB; arith = 1'b1; no_write_o = 1'b1; end
            default: known = 1'b0;
        endcase
        // NZ always follow S; CV only for arithmetic ops
        flag_w_o = (funct_i[0] && known) ? {1'b1, arith} : 2'b00;
        if (!alu_op_i) begin
            alu_control_o = ALU_ADD;
            flag_w_o      = 2'b00;
            no_write_o    = 1'b0;
        end
    end

endmodule

// File: rtl/multicycle_mainfsm.sv
// multicycle_mainfsm: main control FSM of the multicycle ARM core with MemReady waits
// and optional wait timeout. Define MULTICYCLE_BL_EN to add the BLLINK (branch-with-link) state.
module multicycle_mainfsm
    import multicycle_pkg::*;
#(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       PCS,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] FlagW,
    output logic       NoWrite,
    output logic       LinkW,
    output logic       MemFault,
    output logic       Undef,
    output logic [3:0] State
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               nowrite_q, nowrite_d;
    logic               alu_op;
    logic               mem_state;
    logic [1:0]         dec_ctl;
    logic [1:0]         dec_flagw;
    logic               dec_nowrite;

    assign alu_op    = (state_q == EXECR) || (state_q == EXECI);
    assign mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
    assign State     = state_q;

    multicycle_aludec u_aludec (
        .alu_op_i     (alu_op),
        .funct_i      (Funct[4:0]),
        .alu_control_o(dec_ctl),
        .flag_w_o     (dec_flagw),
        .no_write_o   (dec_nowrite)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            nowrite_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nowrite_q <= nowrite_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        nowrite_d  = alu_op ? dec_nowrite : nowrite_q;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        PCS        = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = dec_ctl;
        FlagW      = dec_flagw;
        NoWrite    = dec_nowrite;
        LinkW      = 1'b0;
        MemFault   = 1'b0;
        Undef      = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = MemReady;
                NextPC    = MemReady;
                if (MemReady) state_d = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                case (Op)
                    OP_DP:  state_d = Funct[5] ? EXECI : EXECR;
                    OP_MEM: state_d = MEMADR;
`ifdef MULTICYCLE_BL_EN
                    OP_BR:  state_d = Funct[4] ? BLLINK : BRANCH;
`else
                    OP_BR:  state_d = BRANCH;
`endif
                    default: begin state_d = FETCH; Undef = 1'b1; end
                endcase
            end
            MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
                state_d    = Funct[0] ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = 1'b1;
                PCS       = (Rd == 4'd15);
                state_d   = FETCH;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                if (MemReady) state_d = FETCH;
            end
            EXECR: state_d = ALUWB;
            EXECI: begin ALUSrcB = SRCB_IMM; state_d = ALUWB; end
            ALUWB: begin
                RegW    = 1'b1;
                PCS     = (Rd == 4'd15);
                NoWrite = nowrite_q;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCS       = 1'b1;
                state_d   = FETCH;
            end
`ifdef MULTICYCLE_BL_EN
            BLLINK: begin
                ResultSrc = RES_ALU;
                RegW      = 1'b1;
                LinkW     = 1'b1;
                state_d   = BRANCH;
            end
`endif
            default: state_d = FETCH;
        endcase
        // a ready memory wins over an expiring wait in the same cycle
        if (mem_state && !MemReady) begin
            if (WAIT_LIMIT != 0 && cnt_q == CNT_W'(WAIT_LIMIT)) begin
                MemFault = 1'b1;
                state_d  = FETCH;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (Reset) begin
            IRWrite    = 1'b0;
            NextPC     = 1'b0;
            RegW       = 1'b0;
            MemW       = 1'b0;
            PCS        = 1'b0;
            LinkW      = 1'b0;
            MemFault   = 1'b0;
            Undef      = 1'b0;
            FlagW      = 2'b00;
            NoWrite    = 1'b0;
            AdrSrc     = 1'b0;
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_FOUR;
            ResultSrc  = RES_ALU;
            ALUControl = ALU_ADD;
        end
    end

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// tb_multicycle_mainfsm: directed instruction sequences checked every cycle against a
// behavioural model of the control rules, plus hand-computed literal expectations.
module tb_multicycle_mainfsm;
    localparam int LIMIT = 4;
`ifdef MULTICYCLE_BL_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif
    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4;
    localparam int ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7, ST_ALUWB = 8, ST_BRANCH = 9, ST_BLLINK = 10;

    typedef struct packed {
        logic [3:0] st;
        logic       irw, npc, regw, memw, pcs, adr, srca;
        logic [1:0] srcb, res, aluc, flagw;
        logic       nowr, link, fault, undef;
    } obs_t;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] Op = '0;
    logic [5:0] Funct = '0;
    logic [3:0] Rd = '0;
    logic       MemReady = 1'b0;
    logic       IRWrite, NextPC, RegW, MemW, PCS, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, FlagW;
    logic       NoWrite, LinkW, MemFault, Undef;
    logic [3:0] State;

    int total = 0, bad = 0, cyc = 0;
    int ms = 0, mcnt = 0;
    bit mvalid = 0, mnw = 0;
    logic [31:0] hist;
    int n_regw, n_memw, n_fault, n_link, n_undef;

    multicycle_mainfsm #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Rd(Rd), .MemReady(MemReady),
        .IRWrite(IRWrite), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .PCS(PCS),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ALUControl(ALUControl), .FlagW(FlagW), .NoWrite(NoWrite), .LinkW(LinkW),
        .MemFault(MemFault), .Undef(Undef), .State(State)
    );

    always #5 clk = ~clk;

    // {ALUControl, FlagW, NoWrite} for a data-processing Funct
    function automatic logic [4:0] alu_model(input logic [5:0] f);
        int cmd = int'(f[4:1]);
        logic [1:0] ctl = 2'd0;
        bit known = 1, arith = 0, nw = 0;
        if (cmd == 4) arith = 1;
        else if (cmd == 2) begin ctl = 2'd1; arith = 1; end
        else if (cmd == 0) ctl = 2'd2;
        else if (cmd == 12) ctl = 2'd3;
        else if (cmd == 10) begin ctl = 2'd1; arith = 1; nw = 1; end
        else known = 0;
        return {ctl, (f[0] && known) ? {1'b1, arith} : 2'b00, nw};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic model_check;
        obs_t a, e, m;
        logic [4:0] ad;
        bit tmo, mem;
        int nxt;
        a = '{st: State, irw: IRWrite, npc: NextPC, regw: RegW, memw: MemW, pcs: PCS,
              adr: AdrSrc, srca: ALUSrcA, srcb: ALUSrcB, res: ResultSrc, aluc: ALUControl,
              flagw: FlagW, nowr: NoWrite, link: LinkW, fault: MemFault, undef: Undef};
        e = '0;
        m = '1;
        m.adr = 0; m.srca = 0; m.srcb = 0; m.res = 0;
        if (!mvalid) m.st = 0;
        e.st = 4'(ms);
        ad = alu_model(Funct);
        mem = (ms == ST_FETCH) || (ms == ST_MEMREAD) || (ms == ST_MEMWRITE);
        tmo = mem && !MemReady && (mcnt == LIMIT);
        nxt = ms;
        if (Reset) begin
            e.srca = 1; e.srcb = 2; e.res = 2;
            m.adr = 1; m.srca = 1; m.srcb = 2'b11; m.res = 2'b11;
            nxt = ST_FETCH; mcnt = 0; mvalid = 1;
        end else begin
            if (ms == ST_FETCH) begin
                e.srca = 1; e.srcb = 2; e.res = 2;
                m.adr = 1; m.srca = 1; m.srcb = 2'b11; m.res = 2'b11;
                e.irw = MemReady; e.npc = MemReady;
                nxt = MemReady ? ST_DECODE : ST_FETCH;
            end else if (ms == ST_DECODE) begin
                e.srca = 1; e.srcb = 2; e.res = 2;
                m.srca = 1; m.srcb = 2'b11; m.res = 2'b11;
                e.undef = (Op == 2'b11);
                nxt = (Op == 0) ? (Funct[5] ? ST_EXECI : ST_EXECR) : (Op == 1) ? ST_MEMADR :
                      (Op == 2) ? ((BL && Funct[4]) ? ST_BLLINK : ST_BRANCH) : ST_FETCH;
            end else if (ms == ST_MEMADR) begin
                e.srcb = 1; m.srca = 1; m.srcb = 2'b11;
                e.aluc = Funct[3] ? 2'd0 : 2'd1;
                nxt = Funct[0] ? ST_MEMREAD : ST_MEMWRITE;
            end else if (ms == ST_MEMREAD) begin
                e.adr = 1; m.adr = 1; m.res = 2'b11;
                nxt = MemReady ? ST_MEMWB : ST_MEMREAD;
            end else if (ms == ST_MEMWB) begin
                e.res = 1; m.res = 2'b11;
                e.regw = 1; e.pcs = (Rd == 15);
                nxt = ST_FETCH;
            end else if (ms == ST_MEMWRITE) begin
                e.adr = 1; m.adr = 1; m.res = 2'b11; e.memw = 1;
                nxt = MemReady ? ST_FETCH : ST_MEMWRITE;
            end else if (ms == ST_EXECR || ms == ST_EXECI) begin
                e.srcb = (ms == ST_EXECI) ? 2'd1 : 2'd0; m.srcb = 2'b11;
                m.srca = (ms == ST_EXECR);
                {e.aluc, e.flagw, e.nowr} = ad;
                mnw = ad[0];
                nxt = ST_ALUWB;
            end else if (ms == ST_ALUWB) begin
                m.res = 2'b11; e.regw = 1; e.pcs = (Rd == 15); e.nowr = mnw;
                nxt = ST_FETCH;
            end else if (ms == ST_BRANCH) begin
                e.srcb = 1; e.res = 2; m.srca = 1; m.srcb = 2'b11; m.res = 2'b11;
                e.pcs = 1; nxt = ST_FETCH;
            end else if (ms == ST_BLLINK) begin
                e.res = 2; m.res = 2'b11; e.regw = 1; e.link = 1;
                nxt = ST_BRANCH;
            end
            e.fault = tmo;
            if (tmo) nxt = ST_FETCH;
            mcnt = (mem && !MemReady && !tmo) ? mcnt + 1 : 0;
        end
        total++;
        if ((a & m) !== (e & m)) begin
            bad++;
            $display("FAIL model cycle=%0d got=%h want=%h mask=%h", cyc, a, e, m);
        end
        ms = nxt;
    endtask

    task automatic tick(input logic r, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] rd, input logic mr);
        @(posedge clk);
        #1;
        Reset = r; Op = op; Funct = f; Rd = rd; MemReady = mr;
        @(negedge clk);
        #1;
        cyc++;
        model_check();
        hist = {hist[27:0], State};
        n_regw += int'(RegW); n_memw += int'(MemW); n_fault += int'(MemFault);
        n_link += int'(LinkW); n_undef += int'(Undef);
    endtask

    task automatic begin_test;
        hist = '0; n_regw = 0; n_memw = 0; n_fault = 0; n_link = 0; n_undef = 0;
    endtask

    logic [5:0] alu_f [4] = '{6'b000001, 6'b011000, 6'b011111, 6'b000101};
    logic [1:0] alu_c [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
    logic [1:0] alu_w [4] = '{2'd2, 2'd0, 2'd0, 2'd3};

    initial begin
        begin_test();
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 1);
        chk("rst_state", State, ST_FETCH);
        chk("rst_irw", IRWrite, 0);
        chk("rst_srcb", ALUSrcB, 2);
        chk("rst_res", ResultSrc, 2);

        begin_test();
        repeat (4) tick(0, 2'b00, 6'b001000, 4'd1, 1);
        chk("add_seq", hist, 32'h0000_0168);
        chk("add_regw", RegW, 1);
        chk("add_regw_cnt", n_regw, 1);

        begin_test();
        repeat (3) tick(0, 2'b00, 6'b110101, 4'd2, 1);
        chk("cmp_aluc", ALUControl, 2'b01);
        chk("cmp_flagw", FlagW, 2'b11);
        chk("cmp_nw_exec", NoWrite, 1);
        tick(0, 2'b00, 6'b110101, 4'd2, 1);
        chk("cmp_nw_wb", NoWrite, 1);
        chk("cmp_pcs", PCS, 0);
        chk("cmp_seq", hist, 32'h0000_0178);

        for (int i = 0; i < 4; i++) begin
            repeat (3) tick(0, 2'b00, alu_f[i], 4'(13 + i), 1);
            chk("alu_ctl", ALUControl, alu_c[i]);
            chk("alu_flagw", FlagW, alu_w[i]);
            tick(0, 2'b00, alu_f[i], 4'(13 + i), 1);
        end

        begin_test();
        repeat (3) tick(0, 2'b01, 6'b011001, 4'd15, 1);
        chk("ldr_aluc", ALUControl, 2'b00);
        repeat (3) tick(0, 2'b01, 6'b011001, 4'd15, 0);
        tick(0, 2'b01, 6'b011001, 4'd15, 1);
        tick(0, 2'b01, 6'b011001, 4'd15, 0);
        chk("ldr_regw", RegW, 1);
        chk("ldr_pcs", PCS, 1);
        chk("ldr_seq", hist, 32'h0123_3334);

        begin_test();
        repeat (3) tick(0, 2'b01, 6'b010000, 4'd3, 1);
        chk("str_aluc", ALUControl, 2'b01);
        repeat (5) tick(0, 2'b01, 6'b010000, 4'd3, 0);
        chk("str_fault", MemFault, 1);
        chk("str_memw_cnt", n_memw, 5);
        chk("str_fault_cnt", n_fault, 1);
        chk("str_seq", hist, 32'h0125_5555);

        begin_test();
        repeat (5) tick(0, 2'b00, 6'b000000, 4'd0, 0);
        chk("fetch_fault", MemFault, 1);
        chk("fetch_irw", IRWrite, 0);
        tick(0, 2'b00, 6'b000000, 4'd0, 0);
        chk("fetch_after", State, ST_FETCH);
        chk("fetch_fault_cnt", n_fault, 1);

        begin_test();
        repeat (BL ? 4 : 3) tick(0, 2'b10, 6'b010000, 4'd0, 1);
        chk("bl_pcs", PCS, 1);
        chk("bl_seq", hist, BL ? 32'h0000_01A9 : 32'h0000_0019);
        chk("bl_link_cnt", n_link, BL ? 1 : 0);

        begin_test();
        repeat (2) tick(0, 2'b11, 6'b000000, 4'd0, 1);
        chk("undef", Undef, 1);
        chk("undef_cnt", n_undef, 1);
        tick(0, 2'b11, 6'b000000, 4'd0, 0);
        chk("undef_back", State, ST_FETCH);

        tick(0, 2'b01, 6'b010000, 4'd0, 1);
        repeat (2) tick(0, 2'b01, 6'b010000, 4'd0, 1);
        tick(0, 2'b01, 6'b010000, 4'd0, 0);
        tick(1, 2'b01, 6'b010000, 4'd0, 0);
        chk("rst_mw_state", State, ST_MEMWRITE);
        chk("rst_mw_memw", MemW, 0);
        tick(0, 2'b01, 6'b010000, 4'd0, 0);
        chk("rst_mw_after", State, ST_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
